// File: rtl/cache_line_refill.sv
// -----------------------------------------------------------------------------
// cache_line_refill
//   Read-miss handler that sits between the direct-mapped data cache and the
//   external burst memory.
//
//   On a read miss it issues one burst read command for the 16-byte line,
//   gathers the four returned words, and writes the whole line into the cache
//   with a single fill strobe. In that same cycle it returns the requested word.
//
//   Optional feature macro: CACHE_LINE_REFILL_TIMEOUT_EN
//     When defined, a watchdog aborts a refill that stalls in CMD or BURST for
//     TIMEOUT_CYCLES cycles. It also raises a sticky error flag.
//     When not defined, error is tied low and the FSM waits indefinitely.
//
// Ports
//   clk, rst_n       clock and asynchronous active-low reset
//   miss_valid       requester reports a read miss
//   miss_address     byte address of the missed read (sampled on accept)
//   miss_ready       idle, able to accept a miss
//   mem_cmd_valid    burst read command valid
//   mem_cmd_address  line-aligned burst address
//   mem_cmd_ready    memory accepted the command
//   mem_rdata        burst read word
//   mem_rdata_valid  one burst word valid this cycle
//   fill_enable      one-cycle strobe that writes the line into the cache
//   fill_address     line-aligned fill address ({tag, index, 4'h0})
//   fill_line        {word3, word2, word1, word0}
//   resp_data        requested word, selected by miss_address[3:2]
//   resp_valid       one-cycle pulse, coincident with fill_enable
//   error            sticky watchdog timeout flag
// -----------------------------------------------------------------------------
module cache_line_refill #(
  parameter int LINE_IX_BITWIDTH = 10,
  parameter int ADDR_BITWIDTH    = 32,
  parameter int TIMEOUT_CYCLES   = 255
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     miss_valid,
  input  logic [ADDR_BITWIDTH-1:0] miss_address,
  output logic                     miss_ready,
  output logic                     mem_cmd_valid,
  output logic [ADDR_BITWIDTH-1:0] mem_cmd_address,
  input  logic                     mem_cmd_ready,
  input  logic [31:0]              mem_rdata,
  input  logic                     mem_rdata_valid,
  output logic                     fill_enable,
  output logic [ADDR_BITWIDTH-1:0] fill_address,
  output logic [127:0]             fill_line,
  output logic [31:0]              resp_data,
  output logic                     resp_valid,
  output logic                     error
);

  localparam int TAG_LSB = LINE_IX_BITWIDTH + 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CMD   = 2'd1,
    ST_BURST = 2'd2,
    ST_FILL  = 2'd3
  } state_t;

  state_t                   state_r;
  state_t                   state_next_s;
  logic [1:0]               cnt_r;
  logic [1:0]               word_sel_r;
  logic [3:0][31:0]         words_r;
  logic [3:0][31:0]         line_next_s;
  logic                     accept_s;
  logic                     word_s;
  logic                     last_word_s;
  logic                     waiting_s;
  logic                     timeout_s;

  logic                     miss_ready_r;
  logic                     mem_cmd_valid_r;
  logic [ADDR_BITWIDTH-1:0] mem_cmd_address_r;
  logic                     fill_enable_r;
  logic [ADDR_BITWIDTH-1:0] fill_address_r;
  logic [127:0]             fill_line_r;
  logic [31:0]              resp_data_r;
  logic                     resp_valid_r;

  // The byte offset inside a word is irrelevant: a miss always returns a whole word.
  logic unused_byte_offset_s;
  assign unused_byte_offset_s = ^miss_address[1:0];

  // Handshake decode and line assembly: the incoming word is merged so that
  // the fill does not wait a cycle for words_r to update.
  always_comb begin
    accept_s    = (state_r == ST_IDLE) && miss_valid;
    word_s      = (state_r == ST_BURST) && mem_rdata_valid;
    last_word_s = word_s && (cnt_r == 2'd3);
    waiting_s   = ((state_r == ST_CMD) && !mem_cmd_ready) ||
                  ((state_r == ST_BURST) && !mem_rdata_valid);
    line_next_s = words_r;
    if (word_s) begin
      line_next_s[cnt_r] = mem_rdata;
    end else begin
      line_next_s = words_r;
    end
  end

  // Next-state logic of the refill FSM.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (miss_valid) begin
          state_next_s = ST_CMD;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_CMD: begin
        if (mem_cmd_ready) begin
          state_next_s = ST_BURST;
        end else if (timeout_s) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_CMD;
        end
      end
      ST_BURST: begin
        if (last_word_s) begin
          state_next_s = ST_FILL;
        end else if (timeout_s) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_BURST;
        end
      end
      ST_FILL: begin
        state_next_s = ST_IDLE;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State register plus outputs registered from the next state, so every
  // strobe lines up with the state it belongs to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r         <= ST_IDLE;
      miss_ready_r    <= 1'b1;
      mem_cmd_valid_r <= 1'b0;
      fill_enable_r   <= 1'b0;
      resp_valid_r    <= 1'b0;
    end else begin
      state_r         <= state_next_s;
      miss_ready_r    <= (state_next_s == ST_IDLE);
      mem_cmd_valid_r <= (state_next_s == ST_CMD);
      fill_enable_r   <= (state_next_s == ST_FILL);
      resp_valid_r    <= (state_next_s == ST_FILL);
    end
  end

  // Datapath: address capture on accept, word collection in BURST, and the
  // fill/response registers, which hold their values until the next fill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_cmd_address_r <= {ADDR_BITWIDTH{1'b0}};
      word_sel_r        <= 2'd0;
      cnt_r             <= 2'd0;
      words_r           <= {128{1'b0}};
      fill_address_r    <= {ADDR_BITWIDTH{1'b0}};
      fill_line_r       <= 128'h0;
      resp_data_r       <= 32'h0;
    end else begin
      if (accept_s) begin
        mem_cmd_address_r <= {miss_address[ADDR_BITWIDTH-1:4], 4'h0};
        word_sel_r        <= miss_address[3:2];
        cnt_r             <= 2'd0;
      end
      if (word_s) begin
        words_r <= line_next_s;
        cnt_r   <= cnt_r + 2'd1;
      end
      if (last_word_s) begin
        fill_line_r    <= line_next_s;
        resp_data_r    <= line_next_s[word_sel_r];
        fill_address_r <= {mem_cmd_address_r[ADDR_BITWIDTH-1:TAG_LSB],
                           mem_cmd_address_r[TAG_LSB-1:4], 4'h0};
      end
    end
  end

`ifdef CACHE_LINE_REFILL_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] tmo_r;
  logic             error_r;

  // Abort once the current stall reaches TIMEOUT_CYCLES. Progress on either
  // handshake restarts the count.
  assign timeout_s = waiting_s && (tmo_r == TMO_W'(TIMEOUT_CYCLES - 1));

  // Watchdog counter and sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_r   <= {TMO_W{1'b0}};
      error_r <= 1'b0;
    end else begin
      if (waiting_s && !timeout_s) begin
        tmo_r <= tmo_r + TMO_W'(1);
      end else begin
        tmo_r <= {TMO_W{1'b0}};
      end
      if (timeout_s) begin
        error_r <= 1'b1;
      end
    end
  end

  assign error = error_r;
`else
  logic unused_tmo_s;
  assign unused_tmo_s = waiting_s ^ (TIMEOUT_CYCLES != 32'sd0);
  assign timeout_s    = 1'b0;
  assign error        = 1'b0;
`endif

  assign miss_ready      = miss_ready_r;
  assign mem_cmd_valid   = mem_cmd_valid_r;
  assign mem_cmd_address = mem_cmd_address_r;
  assign fill_enable     = fill_enable_r;
  assign fill_address    = fill_address_r;
  assign fill_line       = fill_line_r;
  assign resp_data       = resp_data_r;
  assign resp_valid      = resp_valid_r;

endmodule
